hour_counter: RTL
=================

HOUR_COUNTER -- requirements
Module: hour_counter

Interface
REQ-001 Parameter: MIN_WRAP, default 59, last minute value before the minute stage wraps to 0.
REQ-002 clk  input  1  single system clock; all sequential logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 minutes  input  7  minute value from the minute counter stage; asynchronous to clk.
REQ-005 set  input  1  synchronous, level-sensitive hour load request.
REQ-006 set_hours  input  5  hour value to load, range 0..23.
REQ-007 mode_12h  input  1  display format select: 1 = 12-hour, 0 = 24-hour.
REQ-008 hours  output  5  registered hour count, range 0..23.
REQ-009 disp_hours  output  5  display hour value: 0..23 when mode_12h=0, 1..12 when mode_12h=1.
REQ-010 pm  output  1  high when hours >= 12.
REQ-011 day_tick  output  1  one-cycle pulse when hours wraps from 23 to 0.
REQ-012 set_err  output  1  one-cycle pulse when a set request carries an out-of-range value.

Function
REQ-013 minutes SHALL pass through a two-flop synchronizer (s1, s2), followed by a delay register s3 that holds the previous s2.
REQ-014 A value SHALL be accepted only at an edge where s2==s3 and s2!=m_acc; at that edge m_acc <= s2.
REQ-015 Latency: for a minutes change held constant, acceptance SHALL occur on the 4th rising clk edge after the change.
REQ-016 Accepted candidates greater than MIN_WRAP SHALL be discarded: m_acc is unchanged and no increment occurs.
REQ-017 A rollover SHALL be detected only on the exact accepted transition from m_acc==MIN_WRAP to a new value of 0; other transitions to 0 (e.g. 37->0) SHALL cause no increment.
REQ-018 On a rollover, hours SHALL advance on the same acceptance edge: hours <= hours+1, with 23 wrapping to 0.
REQ-019 On the 23->0 wrap, day_tick SHALL be 1 for exactly that one following cycle.
REQ-020 When set=1 and set_hours<=23, hours <= set_hours on each edge while set is high; day_tick SHALL not assert for a loaded value.
REQ-021 When set=1 and set_hours>23, hours SHALL be unchanged, set_err SHALL pulse 1 cycle, and the request SHALL be treated as no set.
REQ-022 When a valid set and a rollover coincide, the set SHALL win: the increment is dropped, day_tick stays 0, and m_acc still updates.
REQ-023 When an invalid set and a rollover coincide, the rollover SHALL be processed normally and set_err SHALL pulse.
REQ-024 disp_hours SHALL be combinational: equal to hours when mode_12h=0; when mode_12h=1, (hours mod 12)==0 gives 12, otherwise hours mod 12.
REQ-025 pm SHALL be combinational, equal to (hours>=12), and independent of mode_12h.
REQ-026 A mode_12h change SHALL affect only disp_hours, immediately, and SHALL not alter hours.

Reset
REQ-027 reset=0 SHALL immediately clear hours, day_tick, set_err, s1, s2, s3 and m_acc to 0, independent of clk.
REQ-028 After reset: pm=0; disp_hours=0 when mode_12h=0 and 12 when mode_12h=1.
REQ-029 Reset asserted mid-operation SHALL abandon any pending acceptance; the first rollover after release SHALL require a fresh accepted 59->0 transition.
REQ-030 After reset deassertion, state SHALL change only on rising clk edges.

Verification
REQ-031 The bench SHALL drive reset=0 while hours=17 with no clk edge -> hours=0, pm=0, day_tick=0 at once.
REQ-032 The bench SHALL drive hours=5 and minutes 58->59->0, each held 6 cycles -> hours=6 on exactly the 4th edge after the 59->0 change; no other change.
REQ-033 The bench SHALL drive hours=23 and minutes 59->0 -> hours=0, day_tick high 1 cycle, pm 1->0; mode_12h=1 gives disp_hours 11->12.
REQ-034 The bench SHALL pulse set with set_hours=25 -> set_err 1 cycle, hours unchanged; then set_hours=13 with mode_12h=1 -> hours=13, disp_hours=1, pm=1.
REQ-035 The bench SHALL drive minutes 37->0 (minute stage reset), then a 1-cycle glitch of 59 followed by 0 -> no increment in either case.
REQ-036 The bench SHALL hold set_hours=8 valid on the acceptance edge of a 59->0 rollover with hours=10 -> hours=8, day_tick=0, and no later increment for that rollover.

Source files
------------

// File: rtl/hour_counter.sv
// Hour stage of a clock/calendar chain: accepts minute values from an asynchronous
// minute stage, advances on a 59->0 rollover, and supports load and 12/24h display.
module hour_counter #(
    parameter int unsigned MIN_WRAP = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] minutes,
    input  logic       set,
    input  logic [4:0] set_hours,
    input  logic       mode_12h,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       day_tick,
    output logic       set_err
);

    localparam logic [6:0] MIN_WRAP_L = 7'(MIN_WRAP);
    localparam logic [4:0] HOUR_MAX   = 5'd23;

    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] s3;
    logic [6:0] m_acc;

    logic       accept;
    logic       cand_ok;
    logic       rollover;
    logic       set_valid;
    logic       set_bad;
    logic [4:0] hours_inc;
    logic [4:0] hr_mod;

    // A value is taken only once it has been stable across two synchronized samples,
    // which filters single-cycle glitches from the asynchronous minute bus.
    assign accept    = (s2 == s3) && (s2 != m_acc);
    assign cand_ok   = (s2 <= MIN_WRAP_L);
    assign rollover  = accept && cand_ok && (m_acc == MIN_WRAP_L) && (s2 == 7'd0);
    assign set_valid = set && (set_hours <= HOUR_MAX);
    assign set_bad   = set && (set_hours > HOUR_MAX);
    assign hours_inc = (hours == HOUR_MAX) ? 5'd0 : hours + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 7'd0;
            s2 <= 7'd0;
            s3 <= 7'd0;
        end else begin
            s1 <= minutes;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc <= 7'd0;
        end else if (accept && cand_ok) begin
            m_acc <= s2;
        end
    end

    // A valid load overrides a coincident rollover; an invalid load is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hours    <= 5'd0;
            day_tick <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            set_err  <= set_bad;
            day_tick <= 1'b0;
            if (set_valid) begin
                hours <= set_hours;
            end else if (rollover) begin
                hours    <= hours_inc;
                day_tick <= (hours == HOUR_MAX);
            end
        end
    end

    always_comb begin
        hr_mod = (hours >= 5'd12) ? hours - 5'd12 : hours;
        if (mode_12h) begin
            disp_hours = (hr_mod == 5'd0) ? 5'd12 : hr_mod;
        end else begin
            disp_hours = hours;
        end
    end

    assign pm = (hours >= 5'd12);

endmodule
